// File: rtl/filter_sched.sv
// filter_sched: I/Q sample arbiter and MAC sequencer for a time-shared FIR filter.
//   Ports: clk, reset (async, active-high); i_valid/i_ready, q_valid/q_ready sample handshakes;
//   chan_sel, line_addr, rom_addr, sample_shift, mac_init, mac_en drive the delay lines and MAC;
//   out_req/out_chan/out_ack hand the result downstream; busy is high outside IDLE.
module filter_sched #(
  parameter int N_TAPS = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              q_valid,
  output logic              q_ready,
  output logic              chan_sel,
  output logic [ADDR_W-1:0] line_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              sample_shift,
  output logic              mac_init,
  output logic              mac_en,
  output logic              out_req,
  output logic              out_chan,
  input  logic              out_ack,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, GRANT, SHIFT, MAC, WAIT_ACK} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TAPS - 1);
  state_t state, ns;
  logic [ADDR_W-1:0] cnt, nc;
  logic grant, ng, last_grant, nl, gv;
  assign gv = grant ? q_valid : i_valid;
  always_comb begin
    ns = state;
    nc = '0;
    ng = grant;
    nl = last_grant;
    case (state)
      IDLE: if (i_valid | q_valid) begin
        ns = GRANT;
        ng = (i_valid & q_valid) ? ~last_grant : q_valid;
      end
      GRANT: begin
        ns = gv ? SHIFT : IDLE;
        nl = gv ? grant : last_grant;
      end
      SHIFT: ns = MAC;
      MAC: begin
        ns = (cnt == LAST) ? WAIT_ACK : MAC;
        nc = (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      WAIT_ACK: ns = out_ack ? IDLE : WAIT_ACK;
      default: ns = IDLE;
    endcase
  end
  // Outputs are registered from the next state/counter/grant, so each one is a pure
  // decode of the state registers one cycle later with no input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      i_ready      <= 1'b0;
      q_ready      <= 1'b0;
      chan_sel     <= 1'b0;
      line_addr    <= '0;
      rom_addr     <= '0;
      sample_shift <= 1'b0;
      mac_init     <= 1'b0;
      mac_en       <= 1'b0;
      out_req      <= 1'b0;
      out_chan     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= ns;
      cnt          <= nc;
      grant        <= ng;
      last_grant   <= nl;
      i_ready      <= (ns == GRANT) & ~ng;
      q_ready      <= (ns == GRANT) & ng;
      chan_sel     <= (ns inside {SHIFT, MAC, WAIT_ACK}) & ng;
      line_addr    <= (ns == MAC) ? LAST - nc : '0;
      rom_addr     <= (ns == MAC) ? nc : '0;
      sample_shift <= ns == SHIFT;
      mac_init     <= (ns == MAC) & (nc == '0);
      mac_en       <= ns == MAC;
      out_req      <= ns == WAIT_ACK;
      out_chan     <= (ns == WAIT_ACK) & ng;
      busy         <= ns != IDLE;
    end
  end
endmodule
